alu_seq: RTL

Parametrised multi-cycle successor to the 64-bit combinational ALU. It processes a WIDTH-bit operation as CHUNK-bit slices, least significant slice first, one slice per clock, and registers the carry between slices. The result is returned over a valid/ready handshake. An architectural NZCV flag register is written only when requested, to support ARM flag-setting instructions (ADDS/SUBS/ANDS). It sits between the register-file read stage and writeback in the multi-cycle datapath.

---
 rtl/alu_seq.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle, slice-serial ALU with valid/ready handshakes and an
// architectural NZCV flag register that is written only on request.
// Operands are processed CHUNK bits per clock, least significant slice first,
// with the carry held in a register between slices.
// Optional feature: define ALU_SEQ_ADC_EN to make cntrl 001 an add-with-carry
// that consumes the stored C flag; otherwise 001 is a plain add.
module alu_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       cntrl,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_ADC  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  state_e          state_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  op_e             op_q;
  logic            setf_q;
  logic            carry_q;
  logic            zacc_q;
  logic [IDXW-1:0] idx_q;
  logic            in_ready_q, out_valid_q, busy_q;
  logic            n_q, z_q, c_q, v_q;

  // Slice datapath signals.
  logic [CHUNK-1:0] a_s, b_s, b_eff;
  logic [CHUNK:0]   sum;
  logic [CHUNK-1:0] slice_d;
  logic             is_arith;
  logic             cin_d;
  logic             cflag_d, vflag_d, any_d;

  // Initial carry-in chosen from the incoming opcode at transfer time.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    cin_d = 1'b0;
    unique case (op_e'(cntrl))
      OP_SUB:  cin_d = cntrl[0];
`ifdef ALU_SEQ_ADC_EN
      OP_ADC:  cin_d = c_q;
`else
      OP_ADC:  cin_d = 1'b0;
`endif
      default: cin_d = 1'b0;
    endcase
  end

  // One CHUNK-bit slice of the operation plus its carry/overflow terms.
  always_comb begin
    a_s      = a_q[int'(idx_q)*CHUNK +: CHUNK];
    b_s      = b_q[int'(idx_q)*CHUNK +: CHUNK];
    b_eff    = (op_q == OP_SUB) ? ~b_s : b_s;
    sum      = {1'b0, a_s} + {1'b0, b_eff} + {{CHUNK{1'b0}}, carry_q};
    is_arith = (op_q == OP_ADC) || (op_q == OP_ADD) || (op_q == OP_SUB);
    slice_d  = '0;
    unique case (op_q)
      OP_PASS:                slice_d = b_s;
      OP_ADC, OP_ADD, OP_SUB: slice_d = sum[CHUNK-1:0];
      OP_AND:                 slice_d = a_s & b_s;
      OP_OR:                  slice_d = a_s | b_s;
      OP_XOR:                 slice_d = a_s ^ b_s;
      default:                slice_d = '0;
    endcase
    // Carry into the slice MSB is recovered from the MSB sum bit.
    cflag_d = is_arith & sum[CHUNK];
    vflag_d = is_arith & ((a_s[CHUNK-1] ^ b_eff[CHUNK-1] ^ sum[CHUNK-1]) ^ sum[CHUNK]);
    any_d   = zacc_q | (|slice_d);
  end

  // Control FSM, slice sequencing, result assembly and flag register.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments only, so every
    // read in this block sees the value from before the edge.
    if (!reset_n) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      // NOTE: operand, opcode, carry and zero-accumulator registers are left
      // unreset; they are always loaded on transfer before being consumed.
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            op_q       <= op_e'(cntrl);
            setf_q     <= set_flags;
            carry_q    <= cin_d;
            zacc_q     <= 1'b0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          result_q[int'(idx_q)*CHUNK +: CHUNK] <= slice_d;
          carry_q <= sum[CHUNK];
          zacc_q  <= any_d;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
            if (setf_q) begin
              n_q <= slice_d[CHUNK-1];
              z_q <= ~any_d;
              c_q <= cflag_d;
              v_q <= vflag_d;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign negative  = n_q;
  assign zero      = z_q;
  assign carry_out = c_q;
  assign overflow  = v_q;

endmodule
